// File: rtl/pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_gen: fetch PC generator with trap/redirect handling and a circular RAS. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            trap_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);
    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [XLEN-1:0]  c_pc_step  = XLEN'(4);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_run;
    logic             w_accept;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic             w_redirect_aligned;
    logic [XLEN-1:0]  w_pc_seq;
    logic [PTR_W-1:0] w_top_idx;
    logic [XLEN-1:0]  w_ras_top;

    assign w_run              = (state_q == ST_RUN);
    assign w_accept           = w_run & fetch_ready_i & ~stall_i;
    assign w_ras_empty        = (cnt_q == '0);
    assign w_ras_full         = (cnt_q == c_cnt_full);
    assign w_redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
    assign w_pc_seq           = pc_q + c_pc_step;
    // sp_q points at the next free slot; the top entry sits just below it
    assign w_top_idx          = sp_q - c_ptr_one;
    assign w_ras_top          = ras_q[w_top_idx];

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ras_d      = ras_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        if (w_run) begin
            if (trap_i) begin
                pc_d  = TRAP_VEC;
                sp_d  = '0;
                cnt_d = '0;
            end else if (redirect_i) begin
                if (w_redirect_aligned) begin
                    pc_d = redirect_pc_i;
                end else begin
                    pc_d       = TRAP_VEC;
                    misalign_d = 1'b1;
                    sp_d       = '0;
                    cnt_d      = '0;
                end
            end else if (w_accept) begin
                pc_d = w_pc_seq;
                if (call_i && ret_i) begin
                    if (w_ras_empty) begin
                        ras_d[sp_q] = w_pc_seq;
                        sp_d        = sp_q + c_ptr_one;
                        cnt_d       = c_cnt_one;
                    end else begin
                        pc_d             = w_ras_top;
                        ras_d[w_top_idx] = w_pc_seq;
                    end
                end else if (call_i) begin
                    // A push into a full stack lands on the oldest slot
                    ras_d[sp_q] = w_pc_seq;
                    sp_d        = sp_q + c_ptr_one;
                    if (!w_ras_full) begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end else if (ret_i && !w_ras_empty) begin
                    pc_d  = w_ras_top;
                    sp_d  = w_top_idx;
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            ras_q      <= '{default: '0};
            sp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ras_q      <= ras_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fetch_valid_o = w_run;
    assign pc_o          = pc_q;
    assign misalign_o    = misalign_q;
    assign ras_empty_o   = w_ras_empty;
    assign ras_full_o    = w_ras_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_gen: directed scoreboard bench for pc_gen (XLEN=32 and XLEN=8).      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        n_reset, trap, rd, st, ca, re, rdy;
    logic [31:0] rpc;
    logic        valid, mis, emp, full;
    logic [31:0] pc;

    logic        n_reset8, rd8, rdy8;
    logic [7:0]  rpc8;
    logic        valid8, mis8, emp8, full8;
    logic [7:0]  pc8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        v;
        logic        m;
        logic        e;
        logic        f;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .n_reset(n_reset), .trap_i(trap), .redirect_i(rd),
        .redirect_pc_i(rpc), .stall_i(st), .call_i(ca), .ret_i(re),
        .fetch_ready_i(rdy), .fetch_valid_o(valid), .pc_o(pc),
        .misalign_o(mis), .ras_empty_o(emp), .ras_full_o(full)
    );

    pc_gen #(.XLEN(8), .RESET_VEC(8'h0), .TRAP_VEC(8'h80), .RAS_DEPTH(4)) dut8 (
        .clk(clk), .n_reset(n_reset8), .trap_i(1'b0), .redirect_i(rd8),
        .redirect_pc_i(rpc8), .stall_i(1'b0), .call_i(1'b0), .ret_i(1'b0),
        .fetch_ready_i(rdy8), .fetch_valid_o(valid8), .pc_o(pc8),
        .misalign_o(mis8), .ras_empty_o(emp8), .ras_full_o(full8)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, o, e);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] p, input logic v,
                            input logic m, input logic e, input logic f);
        exp_t x;
        x.tag = tag; x.pc = p; x.v = v; x.m = m; x.e = e; x.f = f;
        sb.push_back(x);
    endtask

    task automatic compare_pop(input bit sel);
        exp_t x;
        logic [31:0] opc;
        logic ov, om, oe, of;
        x = sb.pop_front();
        if (sel) begin
            opc = {24'h0, pc8}; ov = valid8; om = mis8; oe = emp8; of = full8;
        end else begin
            opc = pc; ov = valid; om = mis; oe = emp; of = full;
        end
        chk(x.tag, "pc",    opc,         x.pc);
        chk(x.tag, "valid", {31'h0, ov}, {31'h0, x.v});
        chk(x.tag, "mis",   {31'h0, om}, {31'h0, x.m});
        chk(x.tag, "empty", {31'h0, oe}, {31'h0, x.e});
        chk(x.tag, "full",  {31'h0, of}, {31'h0, x.f});
    endtask

    // Expectation is queued with the stimulus and checked after the next edge
    task automatic step(input bit sel, input string tag, input logic [31:0] p, input logic v,
                        input logic m, input logic e, input logic f);
        push_exp(tag, p, v, m, e, f);
        @(posedge clk);
        #1;
        compare_pop(sel);
    endtask

    task automatic drv(input logic tr_, input logic rd_, input logic [31:0] rpc_,
                       input logic st_, input logic ca_, input logic re_, input logic rdy_);
        trap = tr_; rd = rd_; rpc = rpc_; st = st_; ca = ca_; re = re_; rdy = rdy_;
    endtask

    initial begin
        drv(0, 0, 32'h0, 0, 0, 0, 0);
        n_reset = 1'b0; n_reset8 = 1'b0; rd8 = 1'b0; rpc8 = 8'h0; rdy8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 32'h0, 0, 0, 1, 0); compare_pop(0);

        // T1: boot then sequential fetch
        drv(0, 0, 32'h0, 0, 0, 0, 1);
        n_reset = 1'b1;
        push_exp("boot", 32'h0, 0, 0, 1, 0); compare_pop(0);
        step(0, "t1_run", 32'h0, 1, 0, 1, 0);
        for (int i = 1; i <= 4; i++) step(0, "t1_seq", 32'(i * 4), 1, 0, 1, 0);

        // T2: stall holds, redirect overrides stall
        drv(0, 0, 32'h0, 1, 0, 0, 1);  step(0, "t2_stall1", 32'h10, 1, 0, 1, 0);
        drv(0, 1, 32'h40, 1, 0, 0, 1); step(0, "t2_redir",  32'h40, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 1, 0, 0, 1);  step(0, "t2_stall3", 32'h40, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 0, 0, 1);  step(0, "t2_go",     32'h44, 1, 0, 1, 0);

        // T3: misaligned redirect traps and flushes RAS
        drv(0, 0, 32'h0, 0, 1, 0, 1);  step(0, "t3_call",  32'h48,  1, 0, 0, 0);
        drv(0, 1, 32'h42, 0, 0, 0, 1); step(0, "t3_mis",   32'h100, 1, 1, 1, 0);
        drv(0, 0, 32'h0, 0, 0, 0, 1);  step(0, "t3_clr",   32'h104, 1, 0, 1, 0);

        // T4: five pushes into a 4-deep stack, then drain
        drv(0, 1, 32'h0, 0, 0, 0, 1);  step(0, "t4_r0", 32'h0, 1, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                drv(0, 1, 32'(k * 16), 0, 0, 0, 1);
                step(0, "t4_redir", 32'(k * 16), 1, 0, 0, k >= 4);
            end
            drv(0, 0, 32'h0, 0, 1, 0, 1);
            step(0, "t4_call", 32'(k * 16 + 4), 1, 0, 0, k >= 3);
        end
        for (int j = 0; j < 4; j++) begin
            drv(0, 0, 32'h0, 0, 0, 1, 1);
            step(0, "t4_ret", 32'(32'h44 - j * 16), 1, 0, j == 3, 0);
        end
        drv(0, 0, 32'h0, 0, 0, 1, 1);  step(0, "t4_ret_empty", 32'h18, 1, 0, 1, 0);

        // T5: call and ret in the same accepted cycle
        drv(0, 1, 32'h20, 0, 0, 0, 1); step(0, "t5_r20",     32'h20, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 1, 0, 1);  step(0, "t5_call",    32'h24, 1, 0, 0, 0);
        drv(0, 1, 32'h80, 0, 0, 0, 1); step(0, "t5_r80",     32'h80, 1, 0, 0, 0);
        drv(0, 0, 32'h0, 0, 1, 1, 1);  step(0, "t5_callret", 32'h24, 1, 0, 0, 0);
        drv(0, 0, 32'h0, 0, 0, 1, 1);  step(0, "t5_ret_top", 32'h84, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 1, 1, 1);  step(0, "t5_cr_empty", 32'h88, 1, 0, 0, 0);
        drv(0, 0, 32'h0, 0, 0, 1, 1);  step(0, "t5_ret_push", 32'h88, 1, 0, 1, 0);

        // Stall and not-ready both block RAS updates
        drv(0, 0, 32'h0, 1, 1, 0, 1);  step(0, "stall_call",  32'h88, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 1, 0, 0);  step(0, "nrdy_call",   32'h88, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 1, 0, 1);  step(0, "call_ok",     32'h8C, 1, 0, 0, 0);

        // Trap ignores stall, flushes RAS, and beats a misaligned redirect
        drv(1, 0, 32'h0, 1, 0, 0, 1);  step(0, "trap_stall",  32'h100, 1, 0, 1, 0);
        drv(1, 1, 32'h42, 0, 0, 0, 1); step(0, "trap_mis",    32'h100, 1, 0, 1, 0);
        drv(0, 0, 32'h0, 0, 1, 0, 1);  step(0, "pre_rst",     32'h104, 1, 0, 0, 0);

        // Asynchronous reset mid-run
        drv(0, 0, 32'h0, 0, 0, 0, 1);
        n_reset = 1'b0;
        #2;
        push_exp("async_rst", 32'h0, 0, 0, 1, 0); compare_pop(0);
        n_reset = 1'b1;
        step(0, "rst_run", 32'h0, 1, 0, 1, 0);
        step(0, "rst_seq", 32'h4, 1, 0, 1, 0);

        // T6: XLEN=8 wrap and async reset
        rdy8 = 1'b1; n_reset8 = 1'b1;
        step(1, "t6_boot", 32'h0, 1, 0, 1, 0);
        rd8 = 1'b1; rpc8 = 8'hFC;
        step(1, "t6_rfc",  32'hFC, 1, 0, 1, 0);
        rd8 = 1'b0;
        step(1, "t6_wrap", 32'h00, 1, 0, 1, 0);
        step(1, "t6_seq",  32'h04, 1, 0, 1, 0);
        n_reset8 = 1'b0;
        #2;
        push_exp("t6_rst", 32'h0, 0, 0, 1, 0); compare_pop(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
